wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  N:1 Wishbone master arbiter: several initiators (CPU instr/data ports, DMA) share one slave-side bus.
//  Round-robin grant, held for the whole bus cycle (CYC high), with a watchdog that errors stalled transfers.
//  Sits upstream of the 1:N address-decoding interconnect: N masters -> wb_arbiter -> interconnect -> slaves.
// PARAMETERS
//  N        2   number of masters (>=1)
//  TIMEOUT  255 cycles a strobed transfer may wait for ack/err before arbiter errors it; 0 disables
// PORTS
//  clk             in   1        system clock
//  reset_n         in   1        asynchronous active-low reset
//  wb_we_in[N]     in   1        per-master write enable
//  wb_stb_in[N]    in   1        per-master strobe
//  wb_cyc_in[N]    in   1        per-master cycle request
//  wb_sel_in[N]    in   4        per-master byte selects
//  wb_wdata_in[N]  in   32       per-master write data
//  wb_addr_in[N]   in   32       per-master address
//  wb_err_in[N]    out  1        per-master error
//  wb_ack_in[N]    out  1        per-master acknowledge
//  wb_rdata_in[N]  out  32       per-master read data
//  wb_we_out       out  1        shared-bus write enable
//  wb_stb_out      out  1        shared-bus strobe
//  wb_cyc_out      out  1        shared-bus cycle
//  wb_sel_out      out  4        shared-bus byte selects
//  wb_wdata_out    out  32       shared-bus write data
//  wb_addr_out     out  32       shared-bus address
//  wb_err_out      in   1        shared-bus error
//  wb_ack_out      in   1        shared-bus acknowledge
//  wb_rdata_out    in   32       shared-bus read data
//  grant_idx       out  $clog2(N) (min 1) currently/last granted master, debug
//  busy            out  1        high while FSM in OWNED
// BEHAVIOUR
//  Reset: FSM=IDLE, last_grant=N-1 (master 0 wins first), grant_idx=0, busy=0, wdog=0.
//   Every wb_*_out and every wb_*_in is 0.
//  FSM IDLE: all bus outputs 0; all master ack/err/rdata 0.
//   If any wb_cyc_in[i]: pick first requester scanning last_grant+1 .. last_grant+N (mod N).
//   Register grant_idx/last_grant := pick; -> OWNED. Arbitration costs exactly 1 cycle.
//  FSM OWNED: shared-bus outputs combinationally = granted master's inputs (we, stb, cyc, sel, wdata, addr).
//   Granted master gets wb_ack_out, wb_rdata_out, wb_err_out | wdog_err, all combinational.
//   Non-granted masters see ack=0, err=0, rdata=0 and must wait (their STB is ignored).
//  OWNED -> IDLE when granted wb_cyc_in falls; bus outputs 0 from that same cycle (combinational).
//   Next grant happens earliest one cycle later.
//   Same-cycle drop by owner + new request elsewhere: still via IDLE, new owner chosen by rotation.
//  Watchdog (TIMEOUT>0): counter runs in OWNED while granted stb&cyc high and wb_ack_out|wb_err_out low.
//   Clears on ack/err, on stb low, or on leaving OWNED.
//   When counter == TIMEOUT: wdog_err=1 for exactly that cycle; wb_err_in[grant] asserted; wb_stb_out forced 0 that cycle.
//   Counter then clears. Ownership is kept until the master drops CYC.
//   Counter width $clog2(TIMEOUT+1); it never wraps.
//  Back-to-back transfers inside one CYC are legal; grant is not revoked between them. No priority inversion:
//   a master holding CYC indefinitely starves others by design (software contract).
//  N==1: rotation degenerates, master 0 always granted after 1 idle cycle.
//  Async reset mid-transfer: all outputs 0 immediately; in-flight slave cycle is abandoned (slave sees CYC drop).
// STRUCTURE
//  Shared package wb_pkg: WB_ADDR_W=32, WB_DATA_W=32, WB_SEL_W=4, typedef arb_state_e {ARB_IDLE, ARB_OWNED}.
//  Sub-module rr_picker #(N): combinational; inputs req[N], last[$clog2(N)].
//   Outputs valid and idx of first req after last, with wrap-around.
//  Muxing, FSM and watchdog live in wb_arbiter.
// TESTING
//  1 Reset, no requests 10 cycles -> all outputs 0, busy=0.
//  2 Single master: m0 cyc/stb, addr=0x1000_0000, write 0xDEADBEEF.
//    -> cycle+1: busy=1, grant_idx=0, wb_addr_out=0x1000_0000.
//    -> slave ack reaches only m0.
//  3 Contention, N=3: m0,m1,m2 all cyc at once; each holds one 1-ack transfer then drops.
//    -> grant order 0,1,2, then 0 again with one IDLE cycle between grants.
//  4 Non-owner isolation: m1 owns and is waiting; m0 strobes with ack_out held high.
//    -> m0 ack/err stay 0; m0 gets the bus only after m1 drops cyc.
//  5 Watchdog, TIMEOUT=4: slave never acks.
//    -> exactly 4 cycles after stb, wb_err_in[grant]=1 for 1 cycle, wb_stb_out=0 that cycle; busy stays 1.
//  6 reset_n low mid-OWNED on a write -> same-cycle wb_cyc_out=0; after release, master 0 wins first.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone widths, arbiter state type and index-width helper
package wb_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWNED
    } arb_state_e;

    // An index into N masters still needs one bit when N == 1.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - N-master request side plus shared slave-side Wishbone bus
interface wb_arbiter_if
    import wb_pkg::*;
#(
    parameter int N = 2
);

    logic [N-1:0]                wb_we_in;
    logic [N-1:0]                wb_stb_in;
    logic [N-1:0]                wb_cyc_in;
    logic [N-1:0][WB_SEL_W-1:0]  wb_sel_in;
    logic [N-1:0][WB_DATA_W-1:0] wb_wdata_in;
    logic [N-1:0][WB_ADDR_W-1:0] wb_addr_in;
    logic [N-1:0]                wb_err_in;
    logic [N-1:0]                wb_ack_in;
    logic [N-1:0][WB_DATA_W-1:0] wb_rdata_in;

    logic                        wb_we_out;
    logic                        wb_stb_out;
    logic                        wb_cyc_out;
    logic [WB_SEL_W-1:0]         wb_sel_out;
    logic [WB_DATA_W-1:0]        wb_wdata_out;
    logic [WB_ADDR_W-1:0]        wb_addr_out;
    logic                        wb_err_out;
    logic                        wb_ack_out;
    logic [WB_DATA_W-1:0]        wb_rdata_out;

    // The arbiter: slave to the N initiators, driver of the shared bus.
    modport slave (
        input  wb_we_in, wb_stb_in, wb_cyc_in, wb_sel_in, wb_wdata_in, wb_addr_in,
        output wb_err_in, wb_ack_in, wb_rdata_in,
        output wb_we_out, wb_stb_out, wb_cyc_out, wb_sel_out, wb_wdata_out, wb_addr_out,
        input  wb_err_out, wb_ack_out, wb_rdata_out
    );

    modport master (
        output wb_we_in, wb_stb_in, wb_cyc_in, wb_sel_in, wb_wdata_in, wb_addr_in,
        input  wb_err_in, wb_ack_in, wb_rdata_in,
        input  wb_we_out, wb_stb_out, wb_cyc_out, wb_sel_out, wb_wdata_out, wb_addr_out,
        output wb_err_out, wb_ack_out, wb_rdata_out
    );

endinterface

// File: rtl/wb_arbiter_rr_picker.sv
// rtl/wb_arbiter_rr_picker.sv - combinational round-robin pick of the first request after last
module rr_picker
    import wb_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        logic [IW-1:0] w_cand;
        valid  = 1'b0;
        idx    = '0;
        w_cand = '0;
        // Scan from the farthest candidate inward so the nearest requester after last wins.
        for (int k = N; k >= 1; k--) begin
            w_cand = IW'((int'(last) + k) % N);
            if (req[w_cand]) begin
                valid = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - N:1 round-robin Wishbone arbiter, grant held per CYC, stall watchdog
module wb_arbiter
    import wb_pkg::*;
#(
    parameter  int N       = 2,
    parameter  int TIMEOUT = 255,
    localparam int GW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    wb_arbiter_if.slave   bus,
    output logic [GW-1:0] grant_idx,
    output logic          busy
);

    localparam int            WW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [GW-1:0] LAST_RST = GW'(N - 1);
    localparam bit            WDOG_ON  = (TIMEOUT > 0);

    arb_state_e    r_state;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] r_last;
    logic [WW-1:0] r_wdog;

    logic          w_pick_valid;
    logic [GW-1:0] w_pick_idx;
    logic          w_owned;
    logic          w_active;
    logic          w_gstb;
    logic          w_wdog_err;
    logic          w_wdog_run;

    rr_picker #(.N(N)) u_picker (
        .req   (bus.wb_cyc_in),
        .last  (r_last),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    assign w_owned    = (r_state == ARB_OWNED);
    assign w_active   = w_owned && bus.wb_cyc_in[r_grant];
    assign w_gstb     = w_active && bus.wb_stb_in[r_grant];
    assign w_wdog_err = WDOG_ON && w_gstb && (r_wdog == WW'(TIMEOUT));
    assign w_wdog_run = WDOG_ON && w_gstb && !bus.wb_ack_out && !bus.wb_err_out && !w_wdog_err;

    assign grant_idx = r_grant;
    assign busy      = w_owned;

    // Bus muxing is gated by the owner's live CYC so a dropped cycle vanishes the same clock.
    always_comb begin
        bus.wb_we_out    = 1'b0;
        bus.wb_stb_out   = 1'b0;
        bus.wb_cyc_out   = 1'b0;
        bus.wb_sel_out   = '0;
        bus.wb_wdata_out = '0;
        bus.wb_addr_out  = '0;
        bus.wb_ack_in    = '0;
        bus.wb_err_in    = '0;
        bus.wb_rdata_in  = '0;
        if (w_active) begin
            bus.wb_we_out             = bus.wb_we_in[r_grant];
            bus.wb_stb_out            = w_gstb && !w_wdog_err;
            bus.wb_cyc_out            = 1'b1;
            bus.wb_sel_out            = bus.wb_sel_in[r_grant];
            bus.wb_wdata_out          = bus.wb_wdata_in[r_grant];
            bus.wb_addr_out           = bus.wb_addr_in[r_grant];
            bus.wb_ack_in[r_grant]    = bus.wb_ack_out;
            bus.wb_err_in[r_grant]    = bus.wb_err_out | w_wdog_err;
            bus.wb_rdata_in[r_grant]  = bus.wb_rdata_out;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_last  <= LAST_RST;
            r_wdog  <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    r_wdog <= '0;
                    if (w_pick_valid) begin
                        r_grant <= w_pick_idx;
                        r_last  <= w_pick_idx;
                        r_state <= ARB_OWNED;
                    end
                end
                ARB_OWNED: begin
                    r_wdog <= w_wdog_run ? r_wdog + 1'b1 : '0;
                    if (!bus.wb_cyc_in[r_grant]) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter with N=3, TIMEOUT=4
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int N = 3;

    typedef struct {
        int          gnt;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  grant_idx;
    logic        busy;

    logic        slave_auto = 1'b0;
    logic        force_ack  = 1'b0;
    logic        sb_en      = 1'b0;

    logic [N-1:0]       m_act = '0;
    logic [N-1:0]       m_we  = '0;
    logic [N-1:0][31:0] m_addr = '0;
    logic [N-1:0][31:0] m_wdata = '0;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    wb_arbiter_if #(.N(N)) b ();

    wb_arbiter #(.N(N), .TIMEOUT(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (b.slave),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    assign b.wb_ack_out   = slave_auto ? (b.wb_stb_out & b.wb_cyc_out) : force_ack;
    assign b.wb_err_out   = 1'b0;
    assign b.wb_rdata_out = b.wb_addr_out ^ 32'hA5A5_A5A5;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic drive_masters();
        for (int i = 0; i < N; i++) begin
            b.wb_cyc_in[i]   = m_act[i];
            b.wb_stb_in[i]   = m_act[i];
            b.wb_we_in[i]    = m_we[i];
            b.wb_sel_in[i]   = 4'hF;
            b.wb_wdata_in[i] = m_wdata[i];
            b.wb_addr_in[i]  = m_addr[i];
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int i);
        exp_t e;
        e.gnt = i; e.addr = m_addr[i]; e.we = m_we[i]; e.wdata = m_wdata[i];
        sb.push_back(e);
    endtask

    // Each active master performs one acked transfer then drops CYC.
    task automatic run_masters(input int max_cyc, output int idle_cnt);
        logic [N-1:0] got;
        idle_cnt = 0;
        for (int c = 0; c < max_cyc && (|m_act); c++) begin
            @(negedge clk);
            if (!busy) idle_cnt++;
            got = b.wb_ack_in & m_act;
            @(posedge clk);
            #1;
            m_act = m_act & ~got;
            drive_masters();
        end
        check("run_timeout", 64'(|m_act), 0);
    endtask

    always @(negedge clk) begin
        if (sb_en && b.wb_cyc_out && b.wb_stb_out && b.wb_ack_out) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_xfer", 1, 0);
            end else begin
                exp_t        e;
                logic [2:0]  onehot;
                e      = sb.pop_front();
                onehot = 3'b001 << e.gnt;
                check("sb_grant", 64'(grant_idx), 64'(e.gnt));
                check("sb_addr", b.wb_addr_out, e.addr);
                check("sb_we", b.wb_we_out, e.we);
                check("sb_wdata", b.wb_wdata_out, e.wdata);
                check("sb_ack_only_owner", b.wb_ack_in, onehot);
                check("sb_rdata", b.wb_rdata_in[e.gnt], e.addr ^ 32'hA5A5_A5A5);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int idles;
        drive_masters();

        // 1: reset, then quiet bus
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_idx, 0);
        check("rst_cyc_out", b.wb_cyc_out, 0);
        check("rst_stb_out", b.wb_stb_out, 0);
        check("rst_we_out", b.wb_we_out, 0);
        check("rst_sel_out", b.wb_sel_out, 0);
        check("rst_addr_out", b.wb_addr_out, 0);
        check("rst_wdata_out", b.wb_wdata_out, 0);
        check("rst_ack_in", b.wb_ack_in, 0);
        check("rst_err_in", b.wb_err_in, 0);
        check("rst_rdata_in", b.wb_rdata_in, 0);

        // 2: single master write
        @(posedge clk); #1;
        slave_auto = 1'b1;
        sb_en      = 1'b1;
        m_addr[0] = 32'h1000_0000; m_wdata[0] = 32'hDEAD_BEEF; m_we[0] = 1'b1;
        push_exp(0);
        m_act = 3'b001;
        drive_masters();
        @(negedge clk);
        check("t2_arb_busy", busy, 0);
        check("t2_arb_cyc_out", b.wb_cyc_out, 0);
        @(negedge clk);
        check("t2_busy", busy, 1);
        check("t2_grant", grant_idx, 0);
        check("t2_addr_out", b.wb_addr_out, 32'h1000_0000);
        check("t2_ack_in", b.wb_ack_in, 3'b001);
        @(posedge clk); #1;
        m_act = '0;
        drive_masters();
        idle_cycles(2);
        check("t2_sb_drained", sb.size(), 0);

        // 3: contention among three masters, fresh rotation
        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            m_addr[i] = 32'h2000_0000 + 32'(i * 16);
            m_wdata[i] = $urandom;
            m_we[i] = i[0];
            push_exp(i);
        end
        m_act = 3'b111;
        drive_masters();
        run_masters(40, idles);
        check("t3_idle_cycles", idles, 3);
        for (int i = 0; i < 2; i++) begin
            m_addr[i] = 32'h3000_0000 + 32'(i * 4);
            m_wdata[i] = $urandom;
            push_exp(i);
        end
        m_act = 3'b011;
        drive_masters();
        run_masters(40, idles);
        check("t3_idle_cycles_again", idles, 2);
        idle_cycles(2);
        check("t3_sb_drained", sb.size(), 0);

        // 4: non-owner isolation
        sb_en = 1'b0; slave_auto = 1'b0; force_ack = 1'b0;
        m_addr[1] = 32'h4000_0010; m_addr[0] = 32'h4000_0000;
        m_act = 3'b010;
        drive_masters();
        @(negedge clk);
        @(negedge clk);
        check("t4_grant_m1", grant_idx, 1);
        @(posedge clk); #1;
        m_act = 3'b011; force_ack = 1'b1;
        drive_masters();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_m0_ack", b.wb_ack_in[0], 0);
            check("t4_m0_err", b.wb_err_in[0], 0);
            check("t4_m1_ack", b.wb_ack_in[1], 1);
            check("t4_grant_held", grant_idx, 1);
        end
        @(posedge clk); #1;
        m_act = 3'b001; force_ack = 1'b0;
        drive_masters();
        @(negedge clk);
        check("t4_drop_cyc_out", b.wb_cyc_out, 0);
        @(negedge clk);
        check("t4_idle_gap", busy, 0);
        @(negedge clk);
        check("t4_m0_busy", busy, 1);
        check("t4_m0_grant", grant_idx, 0);
        check("t4_m0_addr", b.wb_addr_out, 32'h4000_0000);
        @(posedge clk); #1;
        m_act = '0;
        drive_masters();
        idle_cycles(2);

        // 5: watchdog with a silent slave
        m_act = 3'b001;
        drive_masters();
        @(negedge clk);
        check("t5_arb_busy", busy, 0);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("t5_err_in", b.wb_err_in[0], (k == 4) ? 1 : 0);
            check("t5_stb_out", b.wb_stb_out, (k == 4) ? 0 : 1);
            check("t5_busy", busy, 1);
        end
        @(posedge clk); #1;
        m_act = '0;
        drive_masters();
        idle_cycles(2);

        // 6: async reset mid-transfer
        m_addr[1] = 32'h5000_0000; m_we[1] = 1'b1; m_wdata[1] = 32'hCAFE_F00D;
        m_act = 3'b010;
        drive_masters();
        @(negedge clk);
        @(negedge clk);
        check("t6_owned", busy, 1);
        check("t6_cyc_before", b.wb_cyc_out, 1);
        reset_n = 1'b0;
        #1;
        check("t6_cyc_out", b.wb_cyc_out, 0);
        check("t6_stb_out", b.wb_stb_out, 0);
        check("t6_busy", busy, 0);
        check("t6_grant", grant_idx, 0);
        m_act = 3'b011;
        drive_masters();
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("t6_first_busy", busy, 1);
        check("t6_first_grant", grant_idx, 0);
        check("t6_first_addr", b.wb_addr_out, m_addr[0]);
        @(posedge clk); #1;
        m_act = '0;
        drive_masters();
        idle_cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
